// File: rtl/cpu_bus_handshake.sv
// cpu_bus_handshake: 68030 bus-mastership arbiter for the DMA CPU state machine.
// Synchronises the asynchronous bus handshakes into SCLK and produces the
// registered BR_/BGACK_O_/BGRANT_ handshake plus the CYCLEDONE termination flag.
// SYNC_STAGES is the synchroniser depth (2..3); REQ_TIMEOUT (1..255) is the
// number of REQ clocks without a sampled grant before a one-clock back-off.
module cpu_bus_handshake #(
    parameter int SYNC_STAGES = 2,
    parameter int REQ_TIMEOUT = 255
) (
    input  logic       SCLK,
    input  logic       RST,
    input  logic       BREQ,
    input  logic       BG_I_,
    input  logic       AS_I_,
    input  logic       BGACK_I_,
    input  logic       DSACK0_I_,
    input  logic       DSACK1_I_,
    input  logic       DREQ_I_,
    output logic       BR_,
    output logic       BGACK_O_,
    output logic       BGRANT_,
    output logic       CYCLEDONE,
    output logic       DSACK0_,
    output logic       DSACK1_,
    output logic       DREQ_,
    output logic [2:0] ARB_STATE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAITBUS = 3'd2,
        OWN     = 3'd3,
        BACKOFF = 3'd4,
        RELEASE = 3'd5
    } arb_state_t;

    // Last counter value spent in REQ before backing off.
    localparam logic [7:0] TIMEOUT_LAST = 8'(REQ_TIMEOUT - 1);

    // Bit order of the synchroniser bank.
    localparam int S_BG     = 0;
    localparam int S_AS     = 1;
    localparam int S_BGACK  = 2;
    localparam int S_DSACK0 = 3;
    localparam int S_DSACK1 = 4;
    localparam int S_DREQ   = 5;

    logic [5:0]                  async_in;
    logic [5:0][SYNC_STAGES-1:0] sync_q;
    logic                        bgs_n;
    logic                        ass_n;
    logic                        bgacks_n;
    logic                        dsack0s_n;
    logic                        dsack1s_n;

    arb_state_t state;
    arb_state_t state_nxt;
    logic [7:0] req_cnt;

    assign async_in = {DREQ_I_, DSACK1_I_, DSACK0_I_, BGACK_I_, AS_I_, BG_I_};

    // ---- stage: input synchronisers (async -> SCLK) ----
    // Shift each asynchronous input through SYNC_STAGES flops; idle-high preset.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (SYNC_STAGES > 1)
                    sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], async_in[i]};
                else
                    sync_q[i] <= {SYNC_STAGES{async_in[i]}};
            end
        end
    end

    assign bgs_n     = sync_q[S_BG][SYNC_STAGES-1];
    assign ass_n     = sync_q[S_AS][SYNC_STAGES-1];
    assign bgacks_n  = sync_q[S_BGACK][SYNC_STAGES-1];
    assign dsack0s_n = sync_q[S_DSACK0][SYNC_STAGES-1];
    assign dsack1s_n = sync_q[S_DSACK1][SYNC_STAGES-1];

    assign DSACK0_ = dsack0s_n;
    assign DSACK1_ = dsack1s_n;
    assign DREQ_   = sync_q[S_DREQ][SYNC_STAGES-1];

    // ---- stage: arbitration FSM ----
    // Next-state decode; a dropped BREQ always wins over a grant seen in the same clock.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (BREQ) state_nxt = REQ;
            end
            REQ: begin
                if (!BREQ)                       state_nxt = IDLE;
                else if (!bgs_n)                 state_nxt = WAITBUS;
                else if (req_cnt == TIMEOUT_LAST) state_nxt = BACKOFF;
            end
            BACKOFF: begin
                state_nxt = BREQ ? REQ : IDLE;
            end
            WAITBUS: begin
                if (!BREQ)                  state_nxt = IDLE;
                else if (ass_n && bgacks_n) state_nxt = OWN;
            end
            OWN: begin
                // A bus cycle in flight is always allowed to finish first.
                if (!BREQ && CYCLEDONE) state_nxt = RELEASE;
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // REQ dwell counter: counts only while staying in REQ, cleared otherwise.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST)                                   req_cnt <= '0;
        else if (state == REQ && state_nxt == REQ) req_cnt <= req_cnt + 8'd1;
        else                                       req_cnt <= '0;
    end

    // ---- stage: registered bus outputs ----
    // Outputs decoded from the next state so they change together with the state flops.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            BR_      <= 1'b1;
            BGACK_O_ <= 1'b1;
            BGRANT_  <= 1'b1;
        end else begin
            BR_      <= !(state_nxt == REQ || state_nxt == WAITBUS);
            BGACK_O_ <= !(state_nxt == OWN);
            BGRANT_  <= !(state_nxt == OWN);
        end
    end

    // Cycle termination: AS_ and both DSACK_ strobes all released in the same clock.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) CYCLEDONE <= 1'b0;
        else     CYCLEDONE <= ass_n && dsack0s_n && dsack1s_n;
    end

    assign ARB_STATE = state;

endmodule

// File: tb/tb_cpu_bus_handshake.sv
// Testbench for cpu_bus_handshake (SYNC_STAGES=2, REQ_TIMEOUT=4).
// Synchroniser/CYCLEDONE latency is checked through a vector table feeding
// expected-value queues; arbitration corners use hand-written sequences.
module tb_cpu_bus_handshake;

    localparam int SYNC = 2;

    logic       SCLK;
    logic       RST;
    logic       BREQ;
    logic       BG_I_;
    logic       AS_I_;
    logic       BGACK_I_;
    logic       DSACK0_I_;
    logic       DSACK1_I_;
    logic       DREQ_I_;
    logic       BR_;
    logic       BGACK_O_;
    logic       BGRANT_;
    logic       CYCLEDONE;
    logic       DSACK0_;
    logic       DSACK1_;
    logic       DREQ_;
    logic [2:0] ARB_STATE;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       dreq;
        logic       d0;
        logic       d1;
        logic       as_n;
        logic [2:0] exp_sync;   // {DREQ_, DSACK0_, DSACK1_}
        logic       exp_cd;
    } vec_t;

    vec_t       vecs[10];
    logic [2:0] sync_q[$];
    logic       cd_q[$];

    logic       tmo_br[10];
    logic [2:0] tmo_st[10];

    cpu_bus_handshake #(
        .SYNC_STAGES(SYNC),
        .REQ_TIMEOUT(4)
    ) dut (
        .SCLK      (SCLK),
        .RST       (RST),
        .BREQ      (BREQ),
        .BG_I_     (BG_I_),
        .AS_I_     (AS_I_),
        .BGACK_I_  (BGACK_I_),
        .DSACK0_I_ (DSACK0_I_),
        .DSACK1_I_ (DSACK1_I_),
        .DREQ_I_   (DREQ_I_),
        .BR_       (BR_),
        .BGACK_O_  (BGACK_O_),
        .BGRANT_   (BGRANT_),
        .CYCLEDONE (CYCLEDONE),
        .DSACK0_   (DSACK0_),
        .DSACK1_   (DSACK1_),
        .DREQ_     (DREQ_),
        .ARB_STATE (ARB_STATE)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge.
    task automatic step();
        @(posedge SCLK);
        #1;
        check("br_bgack_exclusive", {7'd0, BR_ | BGACK_O_}, 8'd1);
    endtask

    task automatic check_state(input string name, input logic [2:0] exp);
        check(name, {5'd0, ARB_STATE}, {5'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        //                dreq d0   d1   as    sync    cd
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b011, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b1};

        tmo_br = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tmo_st = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4};

        // ---------------- reset state ----------------
        RST = 1'b1; BREQ = 1'b0; BG_I_ = 1'b1; AS_I_ = 1'b1; BGACK_I_ = 1'b1;
        DSACK0_I_ = 1'b1; DSACK1_I_ = 1'b1; DREQ_I_ = 1'b0;
        repeat (3) step();
        check("rst_br", {7'd0, BR_}, 8'd1);
        check("rst_bgack", {7'd0, BGACK_O_}, 8'd1);
        check("rst_bgrant", {7'd0, BGRANT_}, 8'd1);
        check("rst_cycledone", {7'd0, CYCLEDONE}, 8'd0);
        check("rst_dreq_sync", {7'd0, DREQ_}, 8'd1);
        check("rst_dsack_sync", {6'd0, DSACK0_, DSACK1_}, 8'd3);
        check_state("rst_state", 3'd0);
        RST = 1'b0;
        DREQ_I_ = 1'b1;
        repeat (4) step();
        check("idle_cycledone", {7'd0, CYCLEDONE}, 8'd1);

        // ---------------- synchroniser / CYCLEDONE latency table ----------------
        for (int i = 0; i < 13; i++) begin
            int k;
            k = (i < 10) ? i : 9;
            DREQ_I_   = vecs[k].dreq;
            DSACK0_I_ = vecs[k].d0;
            DSACK1_I_ = vecs[k].d1;
            AS_I_     = vecs[k].as_n;
            sync_q.push_back(vecs[k].exp_sync);
            cd_q.push_back(vecs[k].exp_cd);
            step();
            if (sync_q.size() >= SYNC) begin
                logic [2:0] e;
                e = sync_q.pop_front();
                check("sync_out", {5'd0, DREQ_, DSACK0_, DSACK1_}, {5'd0, e});
            end
            if (cd_q.size() >= SYNC + 1) begin
                logic e1;
                e1 = cd_q.pop_front();
                check("cycledone_pipe", {7'd0, CYCLEDONE}, {7'd0, e1});
            end
            check_state("table_idle", 3'd0);
        end
        sync_q.delete();
        cd_q.delete();

        // ---------------- normal grant ----------------
        BREQ = 1'b1;
        step();
        check("grant_br_t1", {7'd0, BR_}, 8'd0);
        check_state("grant_req", 3'd1);
        BG_I_ = 1'b0;
        step();
        check_state("grant_req_2", 3'd1);
        step();
        check_state("grant_req_3", 3'd1);
        step();
        check_state("grant_waitbus", 3'd2);
        check("grant_waitbus_br", {7'd0, BR_}, 8'd0);
        check("grant_waitbus_bgrant", {7'd0, BGRANT_}, 8'd1);
        step();
        check_state("grant_own", 3'd3);
        check("own_bgack", {7'd0, BGACK_O_}, 8'd0);
        check("own_br", {7'd0, BR_}, 8'd1);
        check("own_bgrant", {7'd0, BGRANT_}, 8'd0);

        // ---------------- deferred release ----------------
        DSACK1_I_ = 1'b0;
        step();
        step();
        check("defer_dsack1_sync", {7'd0, DSACK1_}, 8'd0);
        check("defer_cd_still_high", {7'd0, CYCLEDONE}, 8'd1);
        step();
        check("defer_cd_low", {7'd0, CYCLEDONE}, 8'd0);
        BREQ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_state("defer_hold_own", 3'd3);
            check("defer_hold_bgack", {7'd0, BGACK_O_}, 8'd0);
        end
        DSACK1_I_ = 1'b1;
        step();
        check("defer_cd_r1", {7'd0, CYCLEDONE}, 8'd0);
        step();
        check("defer_cd_r2", {7'd0, CYCLEDONE}, 8'd0);
        check_state("defer_own_r2", 3'd3);
        step();
        check("defer_cd_r3", {7'd0, CYCLEDONE}, 8'd1);
        check_state("defer_own_r3", 3'd3);
        step();
        check_state("defer_release", 3'd5);
        check("release_bgack", {7'd0, BGACK_O_}, 8'd1);
        check("release_bgrant", {7'd0, BGRANT_}, 8'd1);
        check("release_br", {7'd0, BR_}, 8'd1);
        step();
        check_state("defer_idle", 3'd0);

        // ---------------- bus busy ----------------
        AS_I_ = 1'b0;
        repeat (3) step();
        BREQ = 1'b1;
        step();
        check_state("busy_req", 3'd1);
        step();
        check_state("busy_waitbus", 3'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            check_state("busy_hold", 3'd2);
        end
        AS_I_ = 1'b1;
        step();
        check_state("busy_rel_1", 3'd2);
        step();
        check_state("busy_rel_2", 3'd2);
        step();
        check_state("busy_own", 3'd3);
        check("busy_own_bgack", {7'd0, BGACK_O_}, 8'd0);

        // ---------------- reset while in OWN ----------------
        DREQ_I_ = 1'b0;
        step();
        step();
        check("own_dreq_sync", {7'd0, DREQ_}, 8'd0);
        check_state("own_before_rst", 3'd3);
        #3;
        RST = 1'b1;
        #1;
        check("midrst_bgack", {7'd0, BGACK_O_}, 8'd1);
        check("midrst_br", {7'd0, BR_}, 8'd1);
        check("midrst_bgrant", {7'd0, BGRANT_}, 8'd1);
        check("midrst_cycledone", {7'd0, CYCLEDONE}, 8'd0);
        check("midrst_syncs", {5'd0, DREQ_, DSACK0_, DSACK1_}, 8'd7);
        check_state("midrst_state", 3'd0);
        step();
        check_state("midrst_held", 3'd0);
        RST = 1'b0;
        step();
        check_state("rearb_req", 3'd1);
        BREQ = 1'b0;
        BG_I_ = 1'b1;
        DREQ_I_ = 1'b1;
        repeat (4) step();
        check_state("rearb_idle", 3'd0);

        // ---------------- timeout / back-off ----------------
        BREQ = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("tmo_br", {7'd0, BR_}, {7'd0, tmo_br[i]});
            check_state("tmo_state", tmo_st[i]);
        end
        BREQ = 1'b0;
        step();
        check_state("tmo_to_idle", 3'd0);

        // ---------------- BREQ drop wins over simultaneous grant ----------------
        BREQ = 1'b1;
        step();
        check_state("simul_req", 3'd1);
        BG_I_ = 1'b0;
        step();
        step();
        check_state("simul_req_3", 3'd1);
        BREQ = 1'b0;
        step();
        check_state("simul_idle", 3'd0);
        check("simul_br", {7'd0, BR_}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
